// File: rtl/mips_pkg.sv
// Shared MIPS core types: word width, NOP encoding and the fetch-queue entry.
package mips_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(4);
  endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory read port, control inputs and the decode handshake.
interface mips_fetch_stage_if #(
  parameter int unsigned IMEM_AW = 10
);
  import mips_pkg::*;

  logic                 imem_en;
  logic [IMEM_AW-1:0]   imem_addr;
  logic [WORD_W-1:0]    imem_rdata;
  logic                 halt;
  logic                 redirect_valid;
  logic [WORD_W-1:0]    redirect_pc;
  logic                 id_valid;
  logic                 id_ready;
  logic [WORD_W-1:0]    id_instr;
  logic [WORD_W-1:0]    id_pc;
  logic [WORD_W-1:0]    id_pc_plus4;

  modport master (
    output imem_en, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    input  imem_rdata, halt, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_en, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    output imem_rdata, halt, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/mips_fetch_fifo.sv
// Two-entry fetch queue of {instr, pc}; flush beats push and pop.
module mips_fetch_fifo
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         push_ok_c;
  logic         pop_ok_c;

  always_comb begin
    pop_ok_c  = pop & (count_q != 2'd0);
    push_ok_c = push & ((count_q != 2'd2) | pop_ok_c);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok_c) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push_ok_c) - 2'(pop_ok_c);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch front end: PC, synchronous imem reads, 2-deep queue to decode.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/stall/flush counters.
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       IMEM_AW  = 10
) (
  input  logic              clk,
  input  logic              reset,
  mips_fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [15:0]       perf_flush
`endif
);

  logic [WORD_W-1:0] pc_q;
  logic              inflight_q;
  logic [WORD_W-1:0] inflight_pc_q;
  logic              kill_q;
  fetch_entry_t      hold_q;

  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry_c;
  logic              fifo_empty;
  logic              fifo_full_unused;
  logic [1:0]        fifo_count;

  logic              id_valid_c;
  logic              pop_c;
  logic              push_c;
  logic              issue_c;
  logic [2:0]        occ_sum_c;
  fetch_entry_t      id_entry_c;
  logic              unused_redirect_lsb;

  // Issue only if the queue can absorb every outstanding response after this cycle's pop.
  always_comb begin
    id_valid_c   = ~fifo_empty;
    pop_c        = id_valid_c & bus.id_ready;
    occ_sum_c    = 3'(fifo_count) + 3'(inflight_q);
    issue_c      = reset & ~bus.halt & ~bus.redirect_valid &
                   (occ_sum_c < (3'd2 + 3'(pop_c)));
    push_c       = inflight_q & ~kill_q & ~bus.redirect_valid;
    push_entry_c = '{instr: bus.imem_rdata, pc: inflight_pc_q};
    id_entry_c   = fifo_empty ? hold_q : fifo_head;
  end

  mips_fetch_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_entry_c),
    .pop       (pop_c),
    .flush     (bus.redirect_valid),
    .head      (fifo_head),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // PC, in-flight tracking, and the last presented entry held while the queue is empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
      hold_q        <= '{instr: INSTR_NOP, pc: '0};
    end else begin
      kill_q     <= bus.redirect_valid;
      inflight_q <= issue_c;
      if (issue_c) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_plus4(pc_q);
      end
      if (bus.redirect_valid) begin
        pc_q <= {bus.redirect_pc[WORD_W-1:2], 2'b00};
      end
      if (!fifo_empty) begin
        hold_q <= fifo_head;
      end
    end
  end

  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  assign bus.imem_en     = issue_c;
  assign bus.imem_addr   = pc_q[IMEM_AW+1:2];
  assign bus.id_valid    = id_valid_c;
  assign bus.id_instr    = id_entry_c.instr;
  assign bus.id_pc       = id_entry_c.pc;
  assign bus.id_pc_plus4 = pc_plus4(id_entry_c.pc);

`ifdef FETCH_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
      perf_flush   <= 16'd0;
    end else begin
      if (pop_c && (perf_fetched != '1)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (id_valid_c && !bus.id_ready && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (bus.redirect_valid && (perf_flush != '1)) begin
        perf_flush <= perf_flush + 16'd1;
      end
    end
  end
`endif

endmodule
